// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - core request/response and word-memory port bundle for mem_access_unit
interface mem_access_unit_if #(
   parameter int ROWS    = 64,
   parameter int IO_SIZE = 32
);
   localparam int WA = $clog2(ROWS);
   localparam int AW = WA + 2;

   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [1:0]         req_size;
   logic               req_unsigned;
   logic [AW-1:0]      req_addr;
   logic [IO_SIZE-1:0] req_wdata;

   logic               rsp_valid;
   logic               rsp_ready;
   logic [IO_SIZE-1:0] rsp_rdata;
   logic               rsp_err;

   logic               mem_we;
   logic [WA-1:0]      mem_waddr;
   logic [IO_SIZE-1:0] mem_wdata;
   logic [WA-1:0]      mem_raddr;
   logic [IO_SIZE-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_we, mem_waddr, mem_wdata, mem_raddr
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_we, mem_waddr, mem_wdata, mem_raddr
   );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store unit over a word-addressed memory
// Optional misaligned-access trap: define MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit #(
   parameter int ROWS    = 64,
   parameter int IO_SIZE = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_access_unit_if.slave  bus
);
   localparam int WA = $clog2(ROWS);
   localparam int AW = WA + 2;

   typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

   state_t             state, state_nx;
   logic               r_we;
   logic [1:0]         r_size;
   logic               r_uns;
   logic [AW-1:0]      r_addr;
   logic [IO_SIZE-1:0] r_wdata;
   logic [WA-1:0]      r_raddr;
   logic               r_err;

   logic               accept;
   logic               misalign;
   logic [1:0]         lane;
   logic [4:0]         shamt;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic [IO_SIZE-1:0] lane_mask;
   logic [IO_SIZE-1:0] rd_ext;
   logic [IO_SIZE-1:0] merged;

   assign accept = bus.req_valid && (state == IDLE);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_err <= 1'b0;
      else if (accept) r_err <= misalign;
   end
`else
   assign misalign = 1'b0;
   assign r_err    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_uns   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_raddr <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            r_we    <= bus.req_we;
            r_size  <= bus.req_size;
            r_uns   <= bus.req_unsigned;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
         end
         // Read address only moves when a read is launched, so it idles at its last value.
         if (accept && (state_nx == RD))
            r_raddr <= bus.req_addr[AW-1:2];
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (misalign)                        state_nx = RESP;
               else if (bus.req_we && bus.req_size[1]) state_nx = WR;
               else                                 state_nx = RD;
            end
         end
         RD:      state_nx = r_we ? MERGE : RESP;
         MERGE:   state_nx = RESP;
         WR:      state_nx = RESP;
         RESP:    if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Half accesses drop addr[0] and word accesses drop addr[1:0].
   always_comb begin
      lane = 2'b00;
      if (!r_size[1]) lane = r_size[0] ? {r_addr[1], 1'b0} : r_addr[1:0];
   end

   always_comb begin
      shamt     = {lane, 3'b000};
      byte_sel  = 8'(bus.mem_rdata >> shamt);
      half_sel  = 16'(bus.mem_rdata >> shamt);
      lane_mask = (r_size[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
      merged    = (bus.mem_rdata & ~lane_mask) | ((r_wdata << shamt) & lane_mask);
      case (r_size)
         2'b00:   rd_ext = {{24{~r_uns & byte_sel[7]}}, byte_sel};
         2'b01:   rd_ext = {{16{~r_uns & half_sel[15]}}, half_sel};
         default: rd_ext = bus.mem_rdata;
      endcase
   end

   // Read data comes straight off the memory port; the held read address keeps it stable in RESP.
   assign bus.req_ready = (state == IDLE);
   assign bus.mem_we    = (state == WR) || (state == MERGE);
   assign bus.mem_waddr = r_addr[AW-1:2];
   assign bus.mem_wdata = (state == MERGE) ? merged : r_wdata;
   assign bus.mem_raddr = r_raddr;
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_err   = (state == RESP) && r_err;
   assign bus.rsp_rdata = ((state == RESP) && !r_we && !r_err) ? rd_ext : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst_n;
   logic mem_clr;
   logic [31:0] mem [64];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit_if #(.ROWS(64), .IO_SIZE(32)) bus ();

   mem_access_unit #(.ROWS(64), .IO_SIZE(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(negedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else if (bus.mem_we) begin
         mem[bus.mem_waddr] <= bus.mem_wdata;
      end
   end

   always @(posedge clk) bus.mem_rdata <= mem[bus.mem_raddr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Starts and ends at a negedge with the unit idle.
   task automatic access(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata, input int hold,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int wes);
      logic stable;
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      wes = 0;
      while (!bus.rsp_valid && lat < 20) begin
         if (bus.mem_we) wes++;
         @(negedge clk);
         lat++;
      end
      if (lat >= 20) check("rsp_timeout", 32'(lat), 32'd0);
      rdata  = bus.rsp_rdata;
      err    = bus.rsp_err;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rdata || bus.req_ready !== 1'b0)
            stable = 1'b0;
      end
      if (hold > 0) check("hold_stable", 32'(stable), 32'd1);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic load_chk(input string tag, input logic [1:0] size, input logic uns,
                           input logic [7:0] addr, input logic [31:0] exp);
      int lat, wes;
      logic [31:0] rd;
      logic er;
      access(1'b0, size, uns, addr, 32'h0, 0, lat, rd, er, wes);
      check(tag, rd, exp);
      check({tag, "_lat"}, 32'(lat), 32'd2);
   endtask

   initial begin
      int lat, wes;
      logic [31:0] rd;
      logic er;

      rst_n = 1'b0;
      mem_clr = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("rst_mem_waddr", 32'(bus.mem_waddr), 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_mem_raddr", 32'(bus.mem_raddr), 32'd0);
      rst_n = 1'b1;
      mem_clr = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(bus.req_ready), 32'd1);

      access(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 0, lat, rd, er, wes);
      check("sw_lat", 32'(lat), 32'd2);
      check("sw_we_pulses", 32'(wes), 32'd1);
      check("sw_rdata", rd, 32'h0);
      check("sw_mem4", mem[4], 32'hDEADBEEF);

      load_chk("lw_10", 2'b10, 1'b0, 8'h10, 32'hDEADBEEF);

      access(1'b1, 2'b00, 1'b0, 8'h11, 32'h00000055, 0, lat, rd, er, wes);
      check("sb_lat", 32'(lat), 32'd3);
      check("sb_we_pulses", 32'(wes), 32'd1);
      check("sb_mem4", mem[4], 32'hDEAD55EF);

      load_chk("lb_13_s", 2'b00, 1'b0, 8'h13, 32'hFFFFFFDE);
      load_chk("lb_13_u", 2'b00, 1'b1, 8'h13, 32'h000000DE);
      load_chk("lh_12_s", 2'b01, 1'b0, 8'h12, 32'hFFFFDEAD);
      load_chk("lb_10_s", 2'b00, 1'b0, 8'h10, 32'hFFFFFFEF);
      load_chk("lb_11_s", 2'b00, 1'b0, 8'h11, 32'h00000055);
      load_chk("lh_10_u", 2'b01, 1'b1, 8'h10, 32'h000055EF);
      load_chk("lsz3_10", 2'b11, 1'b0, 8'h10, 32'hDEAD55EF);

      access(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 5, lat, rd, er, wes);
      check("hold_rdata", rd, 32'hDEAD55EF);

      access(1'b1, 2'b01, 1'b0, 8'h12, 32'h1234BEEF, 0, lat, rd, er, wes);
      check("sh_lat", 32'(lat), 32'd3);
      check("sh_we_pulses", 32'(wes), 32'd1);
      check("sh_mem4", mem[4], 32'hBEEF55EF);

      access(1'b0, 2'b10, 1'b0, 8'h12, 32'h0, 0, lat, rd, er, wes);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      check("mis_err", 32'(er), 32'd1);
      check("mis_rdata", rd, 32'h0);
      check("mis_lat", 32'(lat), 32'd1);
`else
      check("mis_err", 32'(er), 32'd0);
      check("mis_rdata", rd, 32'hBEEF55EF);
      check("mis_lat", 32'(lat), 32'd2);
`endif
      check("mis_we_pulses", 32'(wes), 32'd0);

      bus.req_valid = 1'b1;
      bus.req_we = 1'b1;
      bus.req_size = 2'b00;
      bus.req_addr = 8'h10;
      bus.req_wdata = 32'h000000AA;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("merge_we", 32'(bus.mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_we_drop", 32'(bus.mem_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready", 32'(bus.req_ready), 32'd1);
      check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("abort_mem4", mem[4], 32'hBEEF55EF);

      load_chk("post_abort_lw", 2'b10, 1'b0, 8'h10, 32'hBEEF55EF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
